// File: rtl/multi_channel_timer.sv
// Multi-channel compare timer: shared free-running counter with NUM_CH compare channels,
// each one-shot or periodic with a sticky W1C pending bit. Define TIMER_PRESCALER_EN for the prescaler.
module multi_channel_timer #(
    parameter int WIDTH   = 64,
    parameter int NUM_CH  = 4,
    parameter int PRESC_W = 16
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [5:0]        addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic [31:0]       mtime_h,
    output logic [31:0]       mtime_l,
    output logic [NUM_CH-1:0] timer_int
);
    localparam int HI_W = WIDTH - 32;
    localparam logic [WIDTH-1:0] CMP_RESET = '1;

    logic              run_reg;
    logic [WIDTH-1:0]  mtime_reg;
    logic [WIDTH-1:0]  mtime_next;
    logic [WIDTH-1:0]  mtime_inc;
    logic [63:0]       mtime_ext;
    logic [31:0]       shadow_reg;
    logic [31:0]       rdata_reg;
    logic [31:0]       rdata_next;
    logic [31:0]       presc_rd;
    logic [NUM_CH-1:0] pend_reg;
    logic [NUM_CH-1:0] ie_reg;
    logic [NUM_CH-1:0] match;
    logic [NUM_CH-1:0] w1c_mask;
    logic [31:0]       ch_rd [NUM_CH];
    logic              tick;
    logic              advance;
    logic              wr_ctrl;
    logic              wr_clr;
    logic              wr_mtime_l;
    logic              wr_mtime_h;

    assign wr_ctrl    = wr_en && (addr == 6'd0);
    assign wr_clr     = wr_ctrl && wdata[1];
    assign wr_mtime_l = wr_en && (addr == 6'd2);
    assign wr_mtime_h = wr_en && (addr == 6'd3);
    assign w1c_mask   = (wr_en && (addr == 6'd4)) ? wdata[NUM_CH-1:0] : '0;

`ifdef TIMER_PRESCALER_EN
    logic [PRESC_W-1:0] presc_reg;
    logic [PRESC_W-1:0] presc_cnt_reg;

    assign tick     = run_reg && (presc_cnt_reg == presc_reg);
    assign presc_rd = 32'(presc_reg);

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            presc_reg     <= '0;
            presc_cnt_reg <= '0;
        end else begin
            if (wr_en && (addr == 6'd1))
                presc_reg <= wdata[PRESC_W-1:0];
            if (wr_clr || tick)
                presc_cnt_reg <= '0;
            else if (run_reg)
                presc_cnt_reg <= presc_cnt_reg + PRESC_W'(1);
        end
    end
`else
    assign tick     = run_reg;
    assign presc_rd = '0;
`endif

    // A counter overridden by software this edge is not a real increment, so it cannot match.
    assign mtime_inc = mtime_reg + WIDTH'(1);
    assign advance   = tick && !wr_clr && !wr_mtime_l && !wr_mtime_h;
    assign mtime_ext = 64'(mtime_reg);

    always_comb begin
        mtime_next = mtime_reg;
        if (wr_clr)
            mtime_next = '0;
        else if (wr_mtime_l)
            mtime_next[31:0] = wdata;
        else if (wr_mtime_h)
            mtime_next[WIDTH-1:32] = wdata[HI_W-1:0];
        else if (tick)
            mtime_next = mtime_inc;
    end

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic             sel;
        logic             wr_cmp_l;
        logic             wr_cmp_h;
        logic [WIDTH-1:0] cmp_reg;
        logic [31:0]      period_reg;
        logic             periodic_reg;
        logic [63:0]      cmp_ext;

        assign sel      = (addr[5:2] == 4'(gi + 2));
        assign wr_cmp_l = wr_en && sel && (addr[1:0] == 2'd0);
        assign wr_cmp_h = wr_en && sel && (addr[1:0] == 2'd1);
        assign match[gi] = advance && (mtime_inc == cmp_reg);
        assign cmp_ext  = 64'(cmp_reg);

        always_ff @(posedge CLK) begin
            if (!RST_N) begin
                cmp_reg      <= CMP_RESET;
                period_reg   <= '0;
                periodic_reg <= 1'b0;
            end else begin
                if (wr_cmp_l)
                    cmp_reg[31:0] <= wdata;
                else if (wr_cmp_h)
                    cmp_reg[WIDTH-1:32] <= wdata[HI_W-1:0];
                else if (match[gi] && periodic_reg)
                    cmp_reg <= cmp_reg + WIDTH'(period_reg);
                if (wr_en && sel && (addr[1:0] == 2'd2))
                    period_reg <= wdata;
                if (wr_en && sel && (addr[1:0] == 2'd3))
                    periodic_reg <= wdata[0];
            end
        end

        assign ch_rd[gi] = !sel                  ? 32'd0 :
                           (addr[1:0] == 2'd0)   ? cmp_ext[31:0] :
                           (addr[1:0] == 2'd1)   ? cmp_ext[63:32] :
                           (addr[1:0] == 2'd2)   ? period_reg :
                                                   {31'd0, periodic_reg};
    end

    always_comb begin
        rdata_next = '0;
        case (addr)
            6'd0: rdata_next = {31'd0, run_reg};
            6'd1: rdata_next = presc_rd;
            6'd2: rdata_next = mtime_ext[31:0];
            6'd3: rdata_next = shadow_reg;
            6'd4: rdata_next = 32'(pend_reg);
            6'd5: rdata_next = 32'(ie_reg);
            default: begin
                for (int c = 0; c < NUM_CH; c++)
                    rdata_next = rdata_next | ch_rd[c];
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            run_reg    <= 1'b0;
            mtime_reg  <= '0;
            pend_reg   <= '0;
            ie_reg     <= '0;
            shadow_reg <= '0;
            rdata_reg  <= '0;
        end else begin
            mtime_reg <= mtime_next;
            // Hardware set is ORed in after the clear so a coincident match keeps the bit.
            pend_reg  <= (pend_reg & ~w1c_mask) | match;
            if (wr_ctrl)
                run_reg <= wdata[0];
            if (wr_en && (addr == 6'd5))
                ie_reg <= wdata[NUM_CH-1:0];
            if (rd_en) begin
                rdata_reg <= rdata_next;
                if (addr == 6'd2)
                    shadow_reg <= mtime_ext[63:32];
            end
        end
    end

    assign rdata     = rdata_reg;
    assign mtime_l   = mtime_ext[31:0];
    assign mtime_h   = mtime_ext[63:32];
    assign timer_int = pend_reg & ie_reg;

endmodule

// File: tb/tb_multi_channel_timer.sv
// Self-checking bench for multi_channel_timer: directed scenarios plus random register traffic,
// compared every cycle against a register-level reference model.
module tb_multi_channel_timer;
    localparam int NCH = 4;
`ifdef TIMER_PRESCALER_EN
    localparam bit PRESC_EN = 1'b1;
`else
    localparam bit PRESC_EN = 1'b0;
`endif

    logic           CLK;
    logic           RST_N;
    logic           wr_en;
    logic           rd_en;
    logic [5:0]     addr;
    logic [31:0]    wdata;
    logic [31:0]    rdata;
    logic [31:0]    mtime_h;
    logic [31:0]    mtime_l;
    logic [NCH-1:0] timer_int;

    int n_chk = 0;
    int n_err = 0;

    multi_channel_timer #(.WIDTH(64), .NUM_CH(NCH), .PRESC_W(16)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .wr_en     (wr_en),
        .rd_en     (rd_en),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .mtime_h   (mtime_h),
        .mtime_l   (mtime_l),
        .timer_int (timer_int)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference model: architectural register contents.
    logic [63:0] m_time;
    logic [63:0] m_cmp [NCH];
    logic [31:0] m_per [NCH];
    bit          m_periodic [NCH];
    logic [3:0]  m_pend;
    logic [3:0]  m_ie;
    logic [31:0] m_shadow;
    logic [31:0] m_rdata;
    bit          m_run;
    logic [15:0] m_presc;
    logic [15:0] m_pcnt;

    task automatic model_reset();
        m_time = '0; m_pend = '0; m_ie = '0; m_shadow = '0; m_rdata = '0;
        m_run = 1'b0; m_presc = '0; m_pcnt = '0;
        for (int c = 0; c < NCH; c++) begin
            m_cmp[c] = '1; m_per[c] = '0; m_periodic[c] = 1'b0;
        end
    endtask

    function automatic logic [31:0] model_read(input logic [5:0] a);
        int ai;
        int c;
        ai = int'(a);
        if (ai >= 8 && ai < 8 + 4 * NCH) begin
            c = (ai - 8) / 4;
            case ((ai - 8) % 4)
                0: return m_cmp[c][31:0];
                1: return m_cmp[c][63:32];
                2: return m_per[c];
                default: return {31'd0, m_periodic[c]};
            endcase
        end
        case (ai)
            0: return {31'd0, m_run};
            1: return PRESC_EN ? {16'd0, m_presc} : 32'd0;
            2: return m_time[31:0];
            3: return m_shadow;
            4: return {28'd0, m_pend};
            5: return {28'd0, m_ie};
            default: return 32'd0;
        endcase
    endfunction

    // One clock edge of the architecture: reads see old state, hardware updates next,
    // then software writes are layered on top so they take precedence.
    task automatic model_step(input bit wr, input bit rd, input logic [5:0] a, input logic [31:0] d);
        int ai;
        bit tick;
        bit counts;
        logic [63:0] nxt;
        logic [3:0] hit;
        logic [3:0] w1c;
        logic [63:0] old_cmp [NCH];
        ai = int'(a);
        hit = '0;
        w1c = '0;
        if (rd) begin
            m_rdata = model_read(a);
            if (ai == 2) m_shadow = m_time[63:32];
        end
        tick = m_run && (!PRESC_EN || (m_pcnt == m_presc));
        counts = tick && !(wr && ((ai == 0 && d[1]) || ai == 2 || ai == 3));
        nxt = m_time + 64'd1;
        for (int c = 0; c < NCH; c++) begin
            old_cmp[c] = m_cmp[c];
            if (counts && nxt == m_cmp[c]) hit[c] = 1'b1;
        end
        if (PRESC_EN) begin
            if ((wr && ai == 0 && d[1]) || tick) m_pcnt = '0;
            else if (m_run) m_pcnt = m_pcnt + 16'd1;
        end
        if (counts) m_time = nxt;
        for (int c = 0; c < NCH; c++)
            if (hit[c] && m_periodic[c]) m_cmp[c] = m_cmp[c] + {32'd0, m_per[c]};
        if (wr) begin
            if (ai >= 8 && ai < 8 + 4 * NCH) begin
                int c;
                c = (ai - 8) / 4;
                case ((ai - 8) % 4)
                    0: begin m_cmp[c] = old_cmp[c]; m_cmp[c][31:0] = d; end
                    1: begin m_cmp[c] = old_cmp[c]; m_cmp[c][63:32] = d; end
                    2: m_per[c] = d;
                    default: m_periodic[c] = d[0];
                endcase
            end else begin
                case (ai)
                    0: begin m_run = d[0]; if (d[1]) m_time = '0; end
                    1: if (PRESC_EN) m_presc = d[15:0];
                    2: m_time[31:0] = d;
                    3: m_time[63:32] = d;
                    4: w1c = d[3:0];
                    5: m_ie = d[3:0];
                    default: ;
                endcase
            end
        end
        m_pend = (m_pend & ~w1c) | hit;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".mtime"}, {mtime_h, mtime_l}, m_time);
        check({tag, ".timer_int"}, 64'(timer_int), 64'(m_pend & m_ie));
        check({tag, ".rdata"}, 64'(rdata), 64'(m_rdata));
    endtask

    task automatic cyc(input bit wr, input bit rd, input logic [5:0] a, input logic [31:0] d);
        wr_en = wr; rd_en = rd; addr = a; wdata = d;
        @(posedge CLK);
        model_step(wr, rd, a, d);
        #1;
        wr_en = 1'b0; rd_en = 1'b0;
        if (wr) $display("[%0t] write addr=%0d data=%08h", $time, a, d);
        if (rd) $display("[%0t] read  addr=%0d data=%08h", $time, a, rdata);
        check_outputs("cyc");
    endtask

    task automatic wr(input logic [5:0] a, input logic [31:0] d);
        cyc(1'b1, 1'b0, a, d);
    endtask

    task automatic rd(input logic [5:0] a);
        cyc(1'b0, 1'b1, a, 32'd0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 6'd0, 32'd0);
    endtask

    task automatic do_reset(input bit w, input logic [5:0] a, input logic [31:0] d);
        RST_N = 1'b0; wr_en = w; rd_en = 1'b1; addr = a; wdata = d;
        @(posedge CLK);
        model_reset();
        #1;
        RST_N = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
        $display("[%0t] reset", $time);
        check_outputs("reset");
    endtask

    initial begin
        int k;
        int nhit;
        bit clr_next;
        logic [31:0] hit_t [3];

        RST_N = 1'b0; wr_en = 1'b0; rd_en = 1'b0; addr = '0; wdata = '0;
        model_reset();
        do_reset(1'b0, 6'd0, 32'd0);
        do_reset(1'b0, 6'd0, 32'd0);
        check("reset.rdata", 64'(rdata), 64'd0);
        rd(6'd8);
        check("reset.cmp0_l", 64'(rdata), 64'hFFFF_FFFF);

        // Single compare, latency from run to interrupt.
        wr(6'd9, 32'd0);
        wr(6'd8, 32'd10);
        wr(6'd5, 32'd1);
        wr(6'd0, 32'd1);
        k = 21;
        for (int i = 1; i <= 20; i++) begin
            idle(1);
            if (timer_int[0]) begin k = i; break; end
        end
        check("t1.latency", 64'(k), 64'd10);
        check("t1.mtime_at_int", 64'(mtime_l), 64'd10);
        wr(6'd4, 32'd1);
        check("t1.w1c", 64'(timer_int[0]), 64'd0);

        // Prescaler (or plain every-cycle tick when not built in).
        wr(6'd0, 32'd0);
        wr(6'd1, 32'd3);
        wr(6'd0, 32'd3);
        for (int i = 1; i <= 8; i++) begin
            idle(1);
            check("t2.presc_step", 64'(mtime_l), PRESC_EN ? 64'(i / 4) : 64'(i));
        end
        wr(6'd1, 32'd0);

        // Periodic channel 1.
        wr(6'd0, 32'd2);
        wr(6'd4, 32'hF);
        wr(6'd5, 32'd2);
        wr(6'd12, 32'd5);
        wr(6'd13, 32'd0);
        wr(6'd14, 32'd5);
        wr(6'd15, 32'd1);
        wr(6'd0, 32'd1);
        nhit = 0;
        clr_next = 1'b0;
        for (int i = 0; i < 60 && nhit < 3; i++) begin
            if (clr_next) wr(6'd4, 32'd2);
            else idle(1);
            clr_next = 1'b0;
            if (timer_int[1]) begin
                hit_t[nhit] = mtime_l;
                nhit++;
                clr_next = 1'b1;
            end
        end
        check("t3.hits", 64'(nhit), 64'd3);
        for (int i = 0; i < 3; i++)
            if (i < nhit) check("t3.hit_time", 64'(hit_t[i]), 64'(5 * (i + 1)));
        rd(6'd12);
        check("t3.cmp1_after", 64'(rdata), 64'd20);
        wr(6'd4, 32'd2);

        // W1C on the same edge as a hardware set.
        wr(6'd0, 32'd2);
        wr(6'd4, 32'hF);
        wr(6'd16, 32'd6);
        wr(6'd17, 32'd0);
        wr(6'd5, 32'd4);
        wr(6'd0, 32'd1);
        idle(5);
        check("t4.before", 64'(timer_int[2]), 64'd0);
        wr(6'd4, 32'd4);
        check("t4.mtime", 64'(mtime_l), 64'd6);
        check("t4.pend_kept", 64'(timer_int[2]), 64'd1);
        wr(6'd4, 32'd4);
        check("t4.cleared", 64'(timer_int[2]), 64'd0);

        // Match at all-ones, then wrap with no interrupt.
        wr(6'd0, 32'd0);
        for (int c = 0; c < NCH; c++) begin
            wr(6'(8 + 4 * c), 32'hFFFF_FFFF);
            wr(6'(9 + 4 * c), 32'hFFFF_FFFF);
        end
        wr(6'd15, 32'd0);
        wr(6'd4, 32'hF);
        wr(6'd5, 32'hF);
        wr(6'd3, 32'hFFFF_FFFF);
        wr(6'd2, 32'hFFFF_FFFE);
        wr(6'd0, 32'd1);
        idle(1);
        check("t5.all_ones", {mtime_h, mtime_l}, 64'hFFFF_FFFF_FFFF_FFFF);
        check("t5.match_all", 64'(timer_int), 64'hF);
        wr(6'd4, 32'hF);
        check("t5.wrapped", {mtime_h, mtime_l}, 64'd0);
        check("t5.no_wrap_int", 64'(timer_int), 64'd0);
        idle(3);
        check("t5.still_quiet", 64'(timer_int), 64'd0);

        // Coherent read through the shadow.
        wr(6'd0, 32'd0);
        wr(6'd3, 32'd1);
        rd(6'd2);
        wr(6'd3, 32'd7);
        rd(6'd3);
        check("t5.shadow", 64'(rdata), 64'd1);
        check("t5.live_h", 64'(mtime_h), 64'd7);

        // Unmapped and absent-channel addresses.
        wr(6'd24, 32'h1234_5678);
        rd(6'd24);
        check("unmapped.24", 64'(rdata), 64'd0);
        wr(6'd6, 32'hDEAD_BEEF);
        rd(6'd6);
        check("unmapped.6", 64'(rdata), 64'd0);
        rd(6'd1);
        check("presc.read", 64'(rdata), PRESC_EN ? 64'd0 : 64'd0);

        // Random register traffic.
        wr(6'd3, 32'd0);
        wr(6'd2, 32'd0);
        wr(6'd5, 32'hF);
        wr(6'd0, 32'd1);
        for (int i = 0; i < 400; i++) begin
            int op;
            int c;
            op = int'($urandom_range(0, 9));
            c = int'($urandom_range(0, NCH - 1));
            case (op)
                0, 1: idle(1);
                2, 3: rd(6'($urandom_range(0, 63)));
                4: wr(6'd0, {31'd0, ($urandom_range(0, 3) != 0)});
                5: wr(6'd4, $urandom);
                6: wr(6'd5, $urandom);
                7: begin
                    case ($urandom_range(0, 3))
                        0: wr(6'(8 + 4 * c), m_time[31:0] + $urandom_range(1, 40));
                        1: wr(6'(9 + 4 * c), m_time[63:32]);
                        2: wr(6'(10 + 4 * c), $urandom_range(0, 20));
                        default: wr(6'(11 + 4 * c), $urandom);
                    endcase
                end
                8: wr(($urandom_range(0, 1) != 0) ? 6'($urandom_range(6, 7)) : 6'($urandom_range(24, 63)), $urandom);
                default: wr(6'd1, $urandom_range(0, 3));
            endcase
        end

        // Reset mid-count with an interrupt pending.
        wr(6'd0, 32'd0);
        wr(6'd1, 32'd0);
        wr(6'd11, 32'd0);
        wr(6'd9, m_time[63:32]);
        wr(6'd8, m_time[31:0] + 32'd3);
        wr(6'd4, 32'hF);
        wr(6'd5, 32'd1);
        wr(6'd0, 32'd1);
        k = 0;
        for (int i = 0; i < 20; i++) begin
            idle(1);
            if (timer_int[0]) begin k = 1; break; end
        end
        check("t6.int_before", 64'(k), 64'd1);
        rd(6'd8);
        do_reset(1'b1, 6'd5, 32'hF);
        check("t6.rdata", 64'(rdata), 64'd0);
        check("t6.mtime", {mtime_h, mtime_l}, 64'd0);
        check("t6.timer_int", 64'(timer_int), 64'd0);
        rd(6'd8);
        check("t6.cmp0_l", 64'(rdata), 64'hFFFF_FFFF);
        rd(6'd4);
        check("t6.pend", 64'(rdata), 64'd0);
        rd(6'd5);
        check("t6.ie", 64'(rdata), 64'd0);
        rd(6'd0);
        rd(6'd10);
        rd(6'd3);
        idle(3);
        check("t6.stopped", {mtime_h, mtime_l}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
